argmax_unit: RTL and testbench

ARGMAX_UNIT -- requirements
Module: argmax_unit

---
 rtl/argmax_unit_pkg.sv | 30 +++
 rtl/argmax_unit_if.sv | 44 ++++
 rtl/argmax_unit_score_max_cmp.sv | 30 +++
 rtl/argmax_unit.sv | 137 +++++++++++++
 tb/tb_argmax_unit.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/argmax_unit_pkg.sv
// -----------------------------------------------------------------------------
// argmax_unit_pkg
// Shared definitions for the classifier output stage: default class count and
// score width, FSM state encodings and the clogb2 width helper. Also shared with
// the neuron controller, so changes here ripple into both blocks.
// -----------------------------------------------------------------------------
package argmax_unit_pkg;

  localparam int ARGMAX_DEFAULT_N = 10;  // class scores per classification
  localparam int ARGMAX_DEFAULT_W = 16;  // signed score width

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Bits needed to index 0..value-1 (ceil(log2(value))). Returns at least 1
  // so that a single-class configuration still gets a legal vector.
  function automatic int clogb2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/argmax_unit_if.sv
// -----------------------------------------------------------------------------
// argmax_unit_if
// Bundles the classification handshake and result signals.
//   start       : arms a new classification (sampled on rising clk)
//   score_valid : qualifies score; one score is consumed per valid cycle
//   score       : signed class score, W bits
//   busy        : high while collecting scores
//   done        : one-cycle pulse when digit/max_score are fresh
//   digit       : index of the maximum score
//   max_score   : value of the maximum score
//   state_dbg   : current FSM state, for checkers
// Handshake: score_valid has no back-pressure. While busy=1 every cycle with
// score_valid=1 consumes exactly one score; outside collection score_valid is
// ignored. start always wins over a simultaneous score_valid.
// -----------------------------------------------------------------------------
interface argmax_unit_if
  import argmax_unit_pkg::*;
#(
  parameter int N = ARGMAX_DEFAULT_N,
  parameter int W = ARGMAX_DEFAULT_W
);

  localparam int DW = clogb2(N);

  logic                 start;
  logic                 score_valid;
  logic signed [W-1:0]  score;
  logic                 busy;
  logic                 done;
  logic [DW-1:0]        digit;
  logic signed [W-1:0]  max_score;
  state_e               state_dbg;

  modport master (
    output start, score_valid, score,
    input  busy, done, digit, max_score, state_dbg
  );

  modport slave (
    input  start, score_valid, score,
    output busy, done, digit, max_score, state_dbg
  );

endinterface

// File: rtl/argmax_unit_score_max_cmp.sv
// -----------------------------------------------------------------------------
// score_max_cmp
// Combinational signed compare-and-select between two indexed scores.
//   a, a_idx       : first candidate and its class index
//   b, b_idx       : second candidate and its class index
//   win_val/idx    : larger value; on equal values the lower index wins
// -----------------------------------------------------------------------------
module score_max_cmp #(
  parameter int W  = 16,
  parameter int IW = 4
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic [IW-1:0]       a_idx,
  input  logic [IW-1:0]       b_idx,
  output logic signed [W-1:0] win_val,
  output logic [IW-1:0]       win_idx
);

  always_comb begin
    win_val = a;
    win_idx = a_idx;
    // Both operands are declared signed, so this is a full-width signed compare.
    if ((b > a) || ((b == a) && (b_idx < a_idx))) begin
      win_val = b;
      win_idx = b_idx;
    end
  end

endmodule

// File: rtl/argmax_unit.sv
// -----------------------------------------------------------------------------
// argmax_unit
// Collects N signed class scores and reports the index and value of the
// largest one (lowest index on ties).
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : argmax_unit_if slave (start/score_valid/score in,
//         busy/done/digit/max_score/state_dbg out)
// -----------------------------------------------------------------------------
module argmax_unit
  import argmax_unit_pkg::*;
#(
  parameter int N = ARGMAX_DEFAULT_N,
  parameter int W = ARGMAX_DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst,
  argmax_unit_if.slave   bus
);

  localparam int CW = clogb2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [W-1:0]  best_val_q, best_val_d;
  logic [CW-1:0]        best_idx_q, best_idx_d;
  logic                 best_vld_q, best_vld_d;
  logic [CW-1:0]        digit_q, digit_d;
  logic signed [W-1:0]  max_q, max_d;

  logic signed [W-1:0]  win_val;
  logic [CW-1:0]        win_idx;
  logic signed [W-1:0]  cand_val;
  logic [CW-1:0]        cand_idx;
  logic                 consume;
  logic                 last;

  score_max_cmp #(.W(W), .IW(CW)) u_cmp (
    .a       (best_val_q),
    .b       (bus.score),
    .a_idx   (best_idx_q),
    .b_idx   (cnt_q),
    .win_val (win_val),
    .win_idx (win_idx)
  );

  // A restarting start discards a score presented in the same cycle.
  assign consume  = (state_q == ST_COLLECT) && bus.score_valid && !bus.start;
  assign last     = (cnt_q == LAST_IDX);
  // First score of a run is taken as-is; later ones go through the compare.
  assign cand_val = best_vld_q ? win_val : bus.score;
  assign cand_idx = best_vld_q ? win_idx : cnt_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.start) state_d = ST_COLLECT;
      ST_COLLECT: if (consume && last) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    bus.busy      = (state_q == ST_COLLECT);
    bus.done      = (state_q == ST_DONE);
    bus.state_dbg = state_q;
    bus.digit     = digit_q;
    bus.max_score = max_q;
  end

  // Counter, best-so-far and result registers
  always_comb begin
    cnt_d      = cnt_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    best_vld_d = best_vld_q;
    digit_d    = digit_q;
    max_d      = max_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cnt_d      = '0;
          best_vld_d = 1'b0;
        end
      end
      ST_COLLECT: begin
        if (bus.start) begin
          cnt_d      = '0;
          best_vld_d = 1'b0;
        end else if (consume) begin
          best_val_d = cand_val;
          best_idx_d = cand_idx;
          best_vld_d = 1'b1;
          if (last) begin
            // Results load only on the edge entering DONE.
            cnt_d      = '0;
            best_vld_d = 1'b0;
            digit_d    = cand_idx;
            max_d      = cand_val;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      best_vld_q <= 1'b0;
      digit_q    <= '0;
      max_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      best_vld_q <= best_vld_d;
      digit_q    <= digit_d;
      max_q      <= max_d;
    end
  end

endmodule

// File: tb/tb_argmax_unit.sv
// -----------------------------------------------------------------------------
// tb_argmax_unit
// Directed bench for argmax_unit (N=10, W=16). Inputs are driven and outputs
// sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_argmax_unit;
  import argmax_unit_pkg::*;

  localparam int N = 10;
  localparam int W = 16;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   done_pulses;

  argmax_unit_if #(.N(N), .W(W)) bus ();

  argmax_unit #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Counts cycles in which done was high (value before each rising edge).
  always @(posedge clk) begin
    if (bus.done === 1'b1) done_pulses++;
  end

  // Driver: optional start, then ten back-to-back scores. Returns at the
  // falling edge where done is expected.
  task automatic run_class(input int sc[10], input bit do_start);
    if (do_start) begin
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      bus.score_valid = 1'b1;
      bus.score       = sc[i][15:0];
      @(negedge clk);
    end
    bus.score_valid = 1'b0;
    bus.score       = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.score_valid = 1'b0; bus.score = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d expected %0d", bus.state_dbg, ST_IDLE); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.digit !== 4'd0) begin n_bad++; $display("FAIL reset_digit: got %0d expected 0", bus.digit); end
    n_cmp++; if (bus.max_score !== 16'sd0) begin n_bad++; $display("FAIL reset_max: got %0d expected 0", bus.max_score); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int sc[10] = '{3, -5, 40, 7, 40, 0, -1, 12, 39, 2};
    int d0 = done_pulses;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    for (int i = 0; i < 10; i++) begin
      bus.score_valid = 1'b1;
      bus.score       = sc[i][15:0];
      if (i == 9) begin
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL basic_done_early: got %b expected 0", bus.done); end
        n_cmp++; if (bus.digit !== 4'd0) begin n_bad++; $display("FAIL basic_digit_hold: got %0d expected 0", bus.digit); end
      end
      @(negedge clk);
    end
    bus.score_valid = 1'b0;
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL basic_done_cycle11: got %b expected 1", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.digit !== 4'd2) begin n_bad++; $display("FAIL basic_digit: got %0d expected 2", bus.digit); end
    n_cmp++; if (bus.max_score !== 16'sd40) begin n_bad++; $display("FAIL basic_max: got %0d expected 40", bus.max_score); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %b expected 0", bus.done); end
    n_cmp++; if (bus.state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL basic_back_idle: got %0d expected %0d", bus.state_dbg, ST_IDLE); end
    n_cmp++; if (bus.max_score !== 16'sd40) begin n_bad++; $display("FAIL basic_max_hold: got %0d expected 40", bus.max_score); end
    n_cmp++; if (done_pulses - d0 !== 1) begin n_bad++; $display("FAIL basic_pulses: got %0d expected 1", done_pulses - d0); end
  endtask

  task automatic test_all_min();
    int sc[10];
    for (int i = 0; i < 10; i++) sc[i] = -32768;
    run_class(sc, 1'b1);
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL allmin_done: got %b expected 1", bus.done); end
    n_cmp++; if (bus.digit !== 4'd0) begin n_bad++; $display("FAIL allmin_digit: got %0d expected 0", bus.digit); end
    n_cmp++; if (bus.max_score !== -16'sd32768) begin n_bad++; $display("FAIL allmin_max: got %0d expected -32768", bus.max_score); end
    @(negedge clk);
  endtask

  task automatic test_signed();
    int sc[10] = '{-1, -32768, 32767, 32767, -2, 0, 1, -100, 32766, 5};
    run_class(sc, 1'b1);
    n_cmp++; if (bus.digit !== 4'd2) begin n_bad++; $display("FAIL signed_digit: got %0d expected 2", bus.digit); end
    n_cmp++; if (bus.max_score !== 16'sd32767) begin n_bad++; $display("FAIL signed_max: got %0d expected 32767", bus.max_score); end
    @(negedge clk);
  endtask

  task automatic test_gaps();
    int busy_low = 0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL gaps_busy_valid: got %b expected 1 at score %0d", bus.busy, i); end
      bus.score_valid = 1'b1;
      bus.score       = 16'(i);
      @(negedge clk);
      bus.score_valid = 1'b0;
      if (i != 9) begin
        for (int g = 0; g < 3; g++) begin
          n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL gaps_busy_idle: got %b expected 1 after score %0d", bus.busy, i); end
          @(negedge clk);
        end
      end
    end
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL gaps_done: got %b expected 1", bus.done); end
    n_cmp++; if (bus.digit !== 4'd9) begin n_bad++; $display("FAIL gaps_digit: got %0d expected 9", bus.digit); end
    n_cmp++; if (bus.max_score !== 16'sd9) begin n_bad++; $display("FAIL gaps_max: got %0d expected 9", bus.max_score); end
    @(negedge clk);
  endtask

  task automatic test_restart();
    int first[4] = '{500, 1, 2, 3};
    int sc[10]   = '{1, 2, 3, 4, 5, 6, 100, 7, 8, 9};
    int d0       = done_pulses;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.score_valid = 1'b1;
      bus.score       = first[i][15:0];
      @(negedge clk);
    end
    // Restart with a simultaneous score that must be dropped.
    bus.start = 1'b1; bus.score_valid = 1'b1; bus.score = 16'sd1000;
    @(negedge clk);
    bus.start = 1'b0; bus.score_valid = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy: got %b expected 1", bus.busy); end
    run_class(sc, 1'b0);
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL restart_done: got %b expected 1", bus.done); end
    n_cmp++; if (bus.digit !== 4'd6) begin n_bad++; $display("FAIL restart_digit: got %0d expected 6", bus.digit); end
    n_cmp++; if (bus.max_score !== 16'sd100) begin n_bad++; $display("FAIL restart_max: got %0d expected 100", bus.max_score); end
    @(negedge clk);
    n_cmp++; if (done_pulses - d0 !== 1) begin n_bad++; $display("FAIL restart_pulses: got %0d expected 1", done_pulses - d0); end
  endtask

  task automatic test_reset_mid();
    int sc[10] = '{-7, -3, -9, 20, -1, 20, 4, 0, 19, -20};
    int d0 = done_pulses;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.score_valid = 1'b1;
      bus.score       = 16'(50 + i);
      @(negedge clk);
    end
    bus.score_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.digit !== 4'd0) begin n_bad++; $display("FAIL midrst_digit: got %0d expected 0", bus.digit); end
    n_cmp++; if (bus.max_score !== 16'sd0) begin n_bad++; $display("FAIL midrst_max: got %0d expected 0", bus.max_score); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (done_pulses - d0 !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d expected 0", done_pulses - d0); end
    run_class(sc, 1'b1);
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL midrst_rerun_done: got %b expected 1", bus.done); end
    n_cmp++; if (bus.digit !== 4'd3) begin n_bad++; $display("FAIL midrst_rerun_digit: got %0d expected 3", bus.digit); end
    n_cmp++; if (bus.max_score !== 16'sd20) begin n_bad++; $display("FAIL midrst_rerun_max: got %0d expected 20", bus.max_score); end
  endtask

  // Entered at the falling edge where done=1 (left by test_reset_mid).
  task automatic test_ignore();
    int sc[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 2};
    // score_valid and start during DONE
    bus.start = 1'b1; bus.score_valid = 1'b1; bus.score = 16'sd30000;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++; if (bus.state_dbg !== ST_IDLE) begin n_bad++; $display("FAIL ign_done_start: got state %0d expected %0d", bus.state_dbg, ST_IDLE); end
    // score_valid pulses in IDLE
    bus.score = 16'sd31000;
    repeat (3) @(negedge clk);
    bus.score_valid = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ign_idle_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.digit !== 4'd3) begin n_bad++; $display("FAIL ign_digit: got %0d expected 3", bus.digit); end
    n_cmp++; if (bus.max_score !== 16'sd20) begin n_bad++; $display("FAIL ign_max: got %0d expected 20", bus.max_score); end
    // start in the cycle right after DONE is accepted
    run_class(sc, 1'b1);
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL ign_run_done: got %b expected 1", bus.done); end
    bus.start = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ign_start_in_done: got %b expected 0", bus.busy); end
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL ign_start_after_done: got %b expected 1", bus.busy); end
    run_class(sc, 1'b0);
    n_cmp++; if (bus.digit !== 4'd9) begin n_bad++; $display("FAIL ign_final_digit: got %0d expected 9", bus.digit); end
    n_cmp++; if (bus.max_score !== 16'sd2) begin n_bad++; $display("FAIL ign_final_max: got %0d expected 2", bus.max_score); end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    done_pulses = 0;
    test_reset();
    test_basic();
    test_all_min();
    test_signed();
    test_gaps();
    test_restart();
    test_reset_mid();
    test_ignore();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
